mac_stream_param: RTL and testbench
===================================

MAC_STREAM_PARAM -- requirements
Module: mac_stream_param

Interface
REQ-001 SHALL have parameter DATA_W, default 8: operand width.
REQ-002 SHALL have parameter ACC_W, default 24: accumulator width; must satisfy ACC_W >= 2*DATA_W (elaboration error otherwise).
REQ-003 SHALL have parameter LEN_W, default 8: width of the beat-count input.
REQ-004 SHALL have parameter SIGNED, default 0: 0 = unsigned operands, 1 = two's-complement operands.
REQ-005 SHALL have parameter SATURATE, default 0: 0 = accumulator wraps, 1 = accumulator clamps.
REQ-006 SHALL have ports, in this order:
  clk  input  1  clock; all state changes on rising edge
  rst  input  1  reset, asynchronous, active-high
  start  input  1  begin a job; sampled only in IDLE
  len  input  LEN_W  beats in the job; sampled with start; 0 = 2^LEN_W
  clr  input  1  synchronous abort: return to IDLE, zero the accumulator
  in_valid  input  1  operand beat valid
  in_ready  output  1  block accepts a beat this cycle
  ain  input  DATA_W  operand A
  bin  input  DATA_W  operand B
  out_valid  output  1  result valid; held until accepted
  out_ready  input  1  consumer accepts the result
  out_data  output  ACC_W  accumulated result
  ovf  output  1  sticky overflow flag for the current job
  busy  output  1  high in every state except IDLE

Function
REQ-007 SHALL implement the FSM states IDLE, ACCUM, DRAIN and HOLD.
REQ-008 IDLE: start=1 SHALL load the remaining-beat count from len, zero the accumulator, clear ovf, and move to ACCUM.
REQ-009 ACCUM: in_ready=1; a beat SHALL be accepted iff in_valid && in_ready; each accepted beat SHALL decrement the count.
REQ-010 Accepting the last beat SHALL move the FSM to DRAIN and drop in_ready from the following cycle.
REQ-011 Pipeline: operands registered at the acceptance edge k; product registered at edge k+1; accumulator updated at edge k+2.
REQ-012 A pipeline stage SHALL advance only when it holds a valid token; non-beat cycles SHALL leave the accumulator unchanged (bubbles allowed).
REQ-013 DRAIN SHALL move to HOLD at the edge that adds the last product (edge k+2), so out_valid is high in the cycle after edge k+2.
REQ-014 HOLD: out_valid=1 and out_data stable until out_valid && out_ready; that edge SHALL return the FSM to IDLE.
REQ-015 out_data SHALL equal the accumulator register at all times (0 after reset or clr).
REQ-016 Product width SHALL be 2*DATA_W; it SHALL be sign-extended to ACC_W when SIGNED=1 and zero-extended when SIGNED=0.
REQ-017 When SATURATE=0, the sum SHALL wrap modulo 2^ACC_W, and ovf SHALL be set on signed overflow (SIGNED=1) or carry-out (SIGNED=0).
REQ-018 When SATURATE=1, on overflow the accumulator SHALL clamp to the type's max/min (unsigned: 2^ACC_W-1), set ovf, and continue.
REQ-019 ovf SHALL be sticky until the next accepted start, clr or rst.
REQ-020 clr SHALL override every other input in any state: FSM to IDLE, pipeline valids cleared, accumulator, count and ovf zeroed, the same edge.
REQ-021 start outside IDLE SHALL be ignored; in_valid outside ACCUM SHALL be ignored.
REQ-022 start and clr in the same cycle: clr wins, FSM stays IDLE.

Reset
REQ-023 rst=1 SHALL immediately force IDLE, zero all pipeline registers, valids, count, accumulator and ovf, and hold in_ready=0, out_valid=0, busy=0, out_data=0, ovf=0.
REQ-024 Reset asserted mid-job SHALL discard the job; no out_valid SHALL follow reset release without a new start.

Structure
REQ-025 Package mac_pkg SHALL hold the FSM state enum type (mac_state_e) and the saturation min/max constant functions.
REQ-026 The multiply and extend stage SHALL be a sub-module mac_mult_stage (operand regs, product reg, valid bit, SIGNED param).

Verification
REQ-027 Defaults, len=4, beats (1,2),(3,4),(5,6),(7,8) back-to-back -> out_valid 3 cycles after the 4th accept, out_data=100, ovf=0.
REQ-028 Defaults, len=3 with bubbles between beats, (255,255) x3 -> out_data=195075; out_ready low 5 cycles -> out_valid and out_data held.
REQ-029 SIGNED=1, DATA_W=8, ACC_W=16, SATURATE=1, len=2, (-128,-128) x2 -> out_data=32767, ovf=1; same with SATURATE=0 -> out_data=-32768 (0x8000), ovf=1.
REQ-030 clr asserted after 2 of 4 beats -> next cycle IDLE, out_data=0, busy=0; the new job that follows is unaffected by the aborted beats.
REQ-031 rst pulsed mid-DRAIN -> all outputs 0 asynchronously; no out_valid after release; start while busy -> ignored.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared types and constant helpers for the streaming multiply-accumulate block.
package mac_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DRAIN = 2'd2,
      HOLD  = 2'd3
   } mac_state_e;

   // Widest accumulator the clamp helpers can describe.
   localparam int unsigned SAT_CALC_W = 64;

   // Largest representable accumulator value, as a bit pattern in the low acc_w bits.
   function automatic logic [SAT_CALC_W-1:0] sat_max(input int unsigned acc_w, input bit is_signed);
      logic [SAT_CALC_W-1:0] ones;
      ones = '1;
      if (is_signed) return ones >> (SAT_CALC_W + 1 - acc_w);
      else           return ones >> (SAT_CALC_W - acc_w);
   endfunction

   // Smallest representable accumulator value, as a bit pattern in the low acc_w bits.
   function automatic logic [SAT_CALC_W-1:0] sat_min(input int unsigned acc_w, input bit is_signed);
      logic [SAT_CALC_W-1:0] one;
      one = SAT_CALC_W'(1);
      if (is_signed) return one << (acc_w - 1);
      else           return '0;
   endfunction

endpackage

// File: rtl/mac_mult_stage.sv
// Two-stage multiply: operand registers, then product register, each with its own
// valid bit. The product is widened to the accumulator width on the way out.
module mac_mult_stage #(
   parameter int DATA_W = 8,
   parameter int ACC_W  = 24,
   parameter int SIGNED = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr_i,
   input  logic              in_vld_i,
   input  logic [DATA_W-1:0] a_i,
   input  logic [DATA_W-1:0] b_i,
   output logic              op_vld_o,
   output logic              prod_vld_o,
   output logic [ACC_W-1:0]  prod_ext_o
);

   localparam int PROD_W = 2 * DATA_W;

   logic [DATA_W-1:0] a_q, b_q;
   logic [PROD_W-1:0] prod_q, prod_d;
   logic              op_vld_q, prod_vld_q;

   if (SIGNED != 0) begin : g_signed
      // Operands are sign-extended to product width so the low PROD_W bits are exact.
      always_comb prod_d = PROD_W'($signed(a_q)) * PROD_W'($signed(b_q));
      assign prod_ext_o = ACC_W'($signed(prod_q));
   end else begin : g_unsigned
      // Zero-extended operands give the plain unsigned product.
      always_comb prod_d = PROD_W'(a_q) * PROD_W'(b_q);
      assign prod_ext_o = ACC_W'(prod_q);
   end

   // Each stage only loads when the stage in front of it holds a valid token.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_q        <= '0;
         b_q        <= '0;
         prod_q     <= '0;
         op_vld_q   <= 1'b0;
         prod_vld_q <= 1'b0;
      end else if (clr_i) begin
         op_vld_q   <= 1'b0;
         prod_vld_q <= 1'b0;
      end else begin
         op_vld_q   <= in_vld_i;
         prod_vld_q <= op_vld_q;
         if (in_vld_i) begin
            a_q <= a_i;
            b_q <= b_i;
         end
         if (op_vld_q) prod_q <= prod_d;
      end
   end

   assign op_vld_o   = op_vld_q;
   assign prod_vld_o = prod_vld_q;

endmodule

// File: rtl/mac_stream_param.sv
// Streaming multiply-accumulate job engine: take a counted burst of operand pairs,
// sum their products (wrapping or clamping), present the result until consumed.
//
// state | meaning
// IDLE  | waiting for start; accumulator keeps the last result
// ACCUM | accepting operand beats until the count expires
// DRAIN | no more beats; waiting for the last product to reach the accumulator
// HOLD  | result presented on out_valid until out_ready
module mac_stream_param
   import mac_pkg::*;
#(
   parameter int DATA_W   = 8,
   parameter int ACC_W    = 24,
   parameter int LEN_W    = 8,
   parameter int SIGNED   = 0,
   parameter int SATURATE = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [LEN_W-1:0]  len,
   input  logic              clr,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] ain,
   input  logic [DATA_W-1:0] bin,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ACC_W-1:0]  out_data,
   output logic              ovf,
   output logic              busy
);

   if (ACC_W < 2 * DATA_W) begin : g_acc_w_check
      $error("mac_stream_param: ACC_W must be at least 2*DATA_W");
   end

   localparam logic [ACC_W-1:0] SAT_MAX = ACC_W'(sat_max(ACC_W, SIGNED != 0));
   localparam logic [ACC_W-1:0] SAT_MIN = ACC_W'(sat_min(ACC_W, SIGNED != 0));

   mac_state_e       state_q;
   logic [LEN_W-1:0] cnt_q;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic             ovf_q, ovf_hit_d;
   logic             in_ready_q, out_valid_q, busy_q;

   logic             accept;
   logic             op_vld, prod_vld;
   logic [ACC_W-1:0] prod_ext;
   logic [ACC_W:0]   sum_full;

   // A beat is taken only while ACCUM holds in_ready; clr kills it the same edge.
   assign accept = in_valid && in_ready_q && !clr;

   mac_mult_stage #(
      .DATA_W (DATA_W),
      .ACC_W  (ACC_W),
      .SIGNED (SIGNED)
   ) u_mult (
      .clk        (clk),
      .rst        (rst),
      .clr_i      (clr),
      .in_vld_i   (accept),
      .a_i        (ain),
      .b_i        (bin),
      .op_vld_o   (op_vld),
      .prod_vld_o (prod_vld),
      .prod_ext_o (prod_ext)
   );

   // Next accumulator value with overflow detection and optional clamping.
   always_comb begin
      sum_full  = {1'b0, acc_q} + {1'b0, prod_ext};
      ovf_hit_d = 1'b0;
      acc_d     = sum_full[ACC_W-1:0];
      if (SIGNED != 0) begin
         ovf_hit_d = (acc_q[ACC_W-1] == prod_ext[ACC_W-1]) &&
                     (sum_full[ACC_W-1] != acc_q[ACC_W-1]);
         if (SATURATE != 0 && ovf_hit_d) acc_d = acc_q[ACC_W-1] ? SAT_MIN : SAT_MAX;
      end else begin
         ovf_hit_d = sum_full[ACC_W];
         if (SATURATE != 0 && ovf_hit_d) acc_d = SAT_MAX;
      end
   end

   // Job sequencing, beat counting, accumulation and registered handshake outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         acc_q       <= '0;
         ovf_q       <= 1'b0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else if (clr) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         acc_q       <= '0;
         ovf_q       <= 1'b0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         if (prod_vld) begin
            acc_q <= acc_d;
            if (ovf_hit_d) ovf_q <= 1'b1;
         end
         case (state_q)
            IDLE: begin
               if (start) begin
                  // len of zero wraps through the down-counter to give 2^LEN_W beats.
                  cnt_q      <= len;
                  acc_q      <= '0;
                  ovf_q      <= 1'b0;
                  in_ready_q <= 1'b1;
                  busy_q     <= 1'b1;
                  state_q    <= ACCUM;
               end
            end
            ACCUM: begin
               if (accept) begin
                  cnt_q <= cnt_q - 1'b1;
                  if (cnt_q == LEN_W'(1)) begin
                     in_ready_q <= 1'b0;
                     state_q    <= DRAIN;
                  end
               end
            end
            DRAIN: begin
               // With no new beats entering, a product with an empty operand stage is the last.
               if (prod_vld && !op_vld) begin
                  out_valid_q <= 1'b1;
                  state_q     <= HOLD;
               end
            end
            HOLD: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  busy_q      <= 1'b0;
                  state_q     <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_data  = acc_q;
   assign ovf       = ovf_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_mac_stream_param.sv
// Directed bench: one default instance plus two signed 16-bit instances (clamping
// and wrapping) driven by the same stimulus, checked against hand-computed results.
module tb_mac_stream_param;

   logic       clk = 1'b0;
   logic       rst, start, clr, in_valid, out_ready;
   logic [7:0] len, ain, bin;

   logic        u_in_ready, u_out_valid, u_ovf, u_busy;
   logic [23:0] u_out_data;
   logic        s_in_ready, s_out_valid, s_ovf, s_busy;
   logic [15:0] s_out_data;
   logic        w_in_ready, w_out_valid, w_ovf, w_busy;
   logic [15:0] w_out_data;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   mac_stream_param dut_u (
      .clk(clk), .rst(rst), .start(start), .len(len), .clr(clr),
      .in_valid(in_valid), .in_ready(u_in_ready), .ain(ain), .bin(bin),
      .out_valid(u_out_valid), .out_ready(out_ready), .out_data(u_out_data),
      .ovf(u_ovf), .busy(u_busy)
   );

   mac_stream_param #(.DATA_W(8), .ACC_W(16), .LEN_W(8), .SIGNED(1), .SATURATE(1)) dut_s (
      .clk(clk), .rst(rst), .start(start), .len(len), .clr(clr),
      .in_valid(in_valid), .in_ready(s_in_ready), .ain(ain), .bin(bin),
      .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data),
      .ovf(s_ovf), .busy(s_busy)
   );

   mac_stream_param #(.DATA_W(8), .ACC_W(16), .LEN_W(8), .SIGNED(1), .SATURATE(0)) dut_w (
      .clk(clk), .rst(rst), .start(start), .len(len), .clr(clr),
      .in_valid(in_valid), .in_ready(w_in_ready), .ain(ain), .bin(bin),
      .out_valid(w_out_valid), .out_ready(out_ready), .out_data(w_out_data),
      .ovf(w_ovf), .busy(w_busy)
   );

   typedef struct {
      logic [7:0]       len;
      int               nbeats;
      logic [3:0][7:0]  a;
      logic [3:0][7:0]  b;
      int               gap;
      int               hold;
      logic [23:0]      exp_u;
      logic             ovf_u;
      logic [15:0]      exp_s;
      logic             ovf_s;
      logic [15:0]      exp_w;
      logic             ovf_w;
   } vec_t;

   vec_t vt[7];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic release_result();
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk("release_valid", {31'd0, u_out_valid}, 32'd0);
      chk("release_busy", {31'd0, u_busy}, 32'd0);
   endtask

   // Wait for out_valid after the last accept; lat counts cycles from the accept cycle.
   task automatic wait_result(output int lat);
      lat = 1;
      while (!u_out_valid && lat < 12) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic run_job(input vec_t v);
      int t, lat;
      start = 1'b1;
      len   = v.len;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < v.nbeats; i++) begin
         ain      = v.a[i % 4];
         bin      = v.b[i % 4];
         in_valid = 1'b1;
         t = 0;
         while (!u_in_ready && t < 10) begin
            @(negedge clk);
            t++;
         end
         if (!u_in_ready) begin
            chk("accept_timeout", {31'd0, u_in_ready}, 32'd1);
            in_valid = 1'b0;
            return;
         end
         @(negedge clk);
         in_valid = 1'b0;
         if (i < v.nbeats - 1) repeat (v.gap) @(negedge clk);
      end
      chk("in_ready_drop", {31'd0, u_in_ready}, 32'd0);
      wait_result(lat);
      chk("latency", lat, 32'd3);
      chk("data_u", {8'd0, u_out_data}, {8'd0, v.exp_u});
      chk("ovf_u", {31'd0, u_ovf}, {31'd0, v.ovf_u});
      chk("valid_s", {31'd0, s_out_valid}, 32'd1);
      chk("data_s", {16'd0, s_out_data}, {16'd0, v.exp_s});
      chk("ovf_s", {31'd0, s_ovf}, {31'd0, v.ovf_s});
      chk("valid_w", {31'd0, w_out_valid}, 32'd1);
      chk("data_w", {16'd0, w_out_data}, {16'd0, v.exp_w});
      chk("ovf_w", {31'd0, w_ovf}, {31'd0, v.ovf_w});
      for (int h = 0; h < v.hold; h++) begin
         @(negedge clk);
         chk("hold_valid", {31'd0, u_out_valid}, 32'd1);
         chk("hold_data", {8'd0, u_out_data}, {8'd0, v.exp_u});
      end
      release_result();
   endtask

   initial begin
      int lat;

      vt[0] = '{len: 8'd4, nbeats: 4, a: {8'd7, 8'd5, 8'd3, 8'd1}, b: {8'd8, 8'd6, 8'd4, 8'd2},
                gap: 0, hold: 0, exp_u: 24'd100, ovf_u: 1'b0,
                exp_s: 16'd100, ovf_s: 1'b0, exp_w: 16'd100, ovf_w: 1'b0};
      vt[1] = '{len: 8'd3, nbeats: 3, a: {4{8'd255}}, b: {4{8'd255}},
                gap: 2, hold: 5, exp_u: 24'd195075, ovf_u: 1'b0,
                exp_s: 16'd3, ovf_s: 1'b0, exp_w: 16'd3, ovf_w: 1'b0};
      vt[2] = '{len: 8'd1, nbeats: 1, a: {4{8'd10}}, b: {4{8'd20}},
                gap: 0, hold: 1, exp_u: 24'd200, ovf_u: 1'b0,
                exp_s: 16'd200, ovf_s: 1'b0, exp_w: 16'd200, ovf_w: 1'b0};
      vt[3] = '{len: 8'd2, nbeats: 2, a: {8'd0, 8'd0, 8'd7, 8'd0}, b: {8'd0, 8'd0, 8'd0, 8'd5},
                gap: 1, hold: 0, exp_u: 24'd0, ovf_u: 1'b0,
                exp_s: 16'd0, ovf_s: 1'b0, exp_w: 16'd0, ovf_w: 1'b0};
      vt[4] = '{len: 8'd4, nbeats: 4, a: {4{8'd255}}, b: {4{8'd255}},
                gap: 1, hold: 0, exp_u: 24'd260100, ovf_u: 1'b0,
                exp_s: 16'd4, ovf_s: 1'b0, exp_w: 16'd4, ovf_w: 1'b0};
      vt[5] = '{len: 8'd2, nbeats: 2, a: {4{8'h80}}, b: {4{8'h80}},
                gap: 0, hold: 2, exp_u: 24'd32768, ovf_u: 1'b0,
                exp_s: 16'h7FFF, ovf_s: 1'b1, exp_w: 16'h8000, ovf_w: 1'b1};
      vt[6] = '{len: 8'd0, nbeats: 256, a: {4{8'd1}}, b: {4{8'd1}},
                gap: 0, hold: 0, exp_u: 24'd256, ovf_u: 1'b0,
                exp_s: 16'd256, ovf_s: 1'b0, exp_w: 16'd256, ovf_w: 1'b0};

      rst = 1'b1; start = 1'b0; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      len = '0; ain = '0; bin = '0;
      #1;
      chk("rst_in_ready", {31'd0, u_in_ready}, 32'd0);
      chk("rst_out_valid", {31'd0, u_out_valid}, 32'd0);
      chk("rst_busy", {31'd0, u_busy}, 32'd0);
      chk("rst_out_data", {8'd0, u_out_data}, 32'd0);
      chk("rst_ovf", {31'd0, u_ovf}, 32'd0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 7; i++) begin
         run_job(vt[i]);
         repeat (2) @(negedge clk);
      end

      // Abort after two accepted beats, once the first product has landed.
      start = 1'b1; len = 8'd4;
      @(negedge clk);
      start = 1'b0; ain = 8'd100; bin = 8'd100; in_valid = 1'b1;
      @(negedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      chk("pre_clr_data", {8'd0, u_out_data}, 32'd10000);
      chk("pre_clr_busy", {31'd0, u_busy}, 32'd1);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      chk("clr_data", {8'd0, u_out_data}, 32'd0);
      chk("clr_busy", {31'd0, u_busy}, 32'd0);
      chk("clr_in_ready", {31'd0, u_in_ready}, 32'd0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("clr_no_valid", {31'd0, u_out_valid}, 32'd0);
      end
      run_job(vt[0]);
      @(negedge clk);

      // start together with clr in IDLE stays idle.
      start = 1'b1; clr = 1'b1; len = 8'd3;
      @(negedge clk);
      start = 1'b0; clr = 1'b0;
      chk("start_clr_busy", {31'd0, u_busy}, 32'd0);
      chk("start_clr_ready", {31'd0, u_in_ready}, 32'd0);

      // Reset while DRAIN is waiting on the last product.
      start = 1'b1; len = 8'd2;
      @(negedge clk);
      start = 1'b0; ain = 8'd9; bin = 8'd9; in_valid = 1'b1;
      @(negedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      chk("drain_data", {8'd0, u_out_data}, 32'd81);
      chk("drain_busy", {31'd0, u_busy}, 32'd1);
      chk("drain_in_ready", {31'd0, u_in_ready}, 32'd0);
      rst = 1'b1;
      #1;
      chk("arst_data", {8'd0, u_out_data}, 32'd0);
      chk("arst_busy", {31'd0, u_busy}, 32'd0);
      chk("arst_valid", {31'd0, u_out_valid}, 32'd0);
      chk("arst_data_s", {16'd0, s_out_data}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("post_rst_no_valid", {31'd0, u_out_valid}, 32'd0);
      end

      // A second start with a shorter len during ACCUM must not retarget the job.
      start = 1'b1; len = 8'd2;
      @(negedge clk);
      len = 8'd1; ain = 8'd3; bin = 8'd3; in_valid = 1'b1;
      @(negedge clk);
      start = 1'b0; in_valid = 1'b0;
      chk("ignored_start_ready", {31'd0, u_in_ready}, 32'd1);
      chk("ignored_start_busy", {31'd0, u_busy}, 32'd1);
      ain = 8'd4; bin = 8'd4; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      wait_result(lat);
      chk("ignored_start_lat", lat, 32'd3);
      chk("ignored_start_data", {8'd0, u_out_data}, 32'd25);
      release_result();

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
